// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding, error codes and defaults for the program loader
package loader_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_HI,
      ST_LO,
      ST_CSUM,
      ST_DONE
   } state_t;
   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_HI      = 2'd1;
   localparam logic [1:0] ERR_CSUM    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;
   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
endpackage

// File: rtl/load_timeout.sv
// load_timeout: byte-gap watchdog for a frame in progress
// Ports: clk, rst (sync, active-high); run = frame active; kick = byte received (clears the gap);
// expired = gap has reached TIMEOUT_CYCLES while running.
module load_timeout #(
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic kick,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt;
   // Counter parks at the limit so expired stays asserted until the FSM drops run.
   always_ff @(posedge clk) begin
      if (rst || kick || !run) cnt <= '0;
      else if (!expired) cnt <= cnt + CW'(1);
   end
   assign expired = run && (cnt == CW'(TIMEOUT_CYCLES));
endmodule

// File: rtl/inst_loader.sv
// inst_loader: UART-fed loader writing 13-bit words into the 256-entry instruction memory
// Ports: clk, rst (sync, active-high); rx_valid/rx_data = received byte strobe;
// wr_en/wr_addr/wr_data = instruction memory write port; core_hold/core_start = PC control;
// load_busy = frame in progress; err_code = sticky error (0 none, 1 bad HI, 2 checksum, 3 timeout).
// Option: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module inst_loader
   import loader_pkg::*;
#(
   parameter int         TIMEOUT_CYCLES = 2_000_000,
   parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        wr_en,
   output logic [7:0]  wr_addr,
   output logic [12:0] wr_data,
   output logic        core_hold,
   output logic        core_start,
   output logic        load_busy,
   output logic [1:0]  err_code
);
`ifdef LOADER_CHECKSUM_EN
   localparam state_t ST_END = ST_CSUM;
   logic [7:0] csum;
`else
   localparam state_t ST_END = ST_DONE;
`endif
   state_t     state, state_nx;
   logic [7:0] n, addr;
   logic [4:0] hi;
   logic       hold, expired, last;
   logic [1:0] err;

   load_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .run    (load_busy),
      .kick   (rx_valid),
      .expired(expired)
   );

   assign last = (addr == n - 8'd1);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else state <= state_nx;
   end

   // A received byte always wins over a timeout expiring in the same cycle.
   always_comb begin
      state_nx = state;
      if (state == ST_DONE) state_nx = ST_IDLE;
      else if (rx_valid)
         case (state)
            ST_IDLE: state_nx = (rx_data == SYNC_BYTE) ? ST_LEN : ST_IDLE;
            ST_LEN:  state_nx = (rx_data == 8'd0) ? ST_END : ST_HI;
            ST_HI:   state_nx = (rx_data[7:5] != 3'd0) ? ST_IDLE : ST_LO;
            ST_LO:   state_nx = last ? ST_END : ST_HI;
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: state_nx = (rx_data == csum) ? ST_DONE : ST_IDLE;
`endif
            default: state_nx = ST_IDLE;
         endcase
      else if (expired) state_nx = ST_IDLE;
   end

   // Datapath; hold survives error exits and is only released by DONE or rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         hold    <= 1'b0;
         err     <= ERR_NONE;
         n       <= '0;
         addr    <= '0;
         hi      <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum    <= '0;
`endif
      end else begin
         wr_en <= 1'b0;
         if (state == ST_DONE) hold <= 1'b0;
         if (rx_valid)
            case (state)
               ST_IDLE:
                  if (rx_data == SYNC_BYTE) begin
                     err  <= ERR_NONE;
                     hold <= 1'b1;
                     addr <= '0;
`ifdef LOADER_CHECKSUM_EN
                     csum <= '0;
`endif
                  end
               ST_LEN: begin
                  n <= rx_data;
`ifdef LOADER_CHECKSUM_EN
                  csum <= csum ^ rx_data;
`endif
               end
               ST_HI:
                  if (rx_data[7:5] != 3'd0) err <= ERR_HI;
                  else begin
                     hi <= rx_data[4:0];
`ifdef LOADER_CHECKSUM_EN
                     csum <= csum ^ rx_data;
`endif
                  end
               ST_LO: begin
                  wr_en   <= 1'b1;
                  wr_addr <= addr;
                  wr_data <= {hi, rx_data};
                  addr    <= addr + 8'd1;
`ifdef LOADER_CHECKSUM_EN
                  csum    <= csum ^ rx_data;
`endif
               end
`ifdef LOADER_CHECKSUM_EN
               ST_CSUM: if (rx_data != csum) err <= ERR_CSUM;
`endif
               default: ;
            endcase
         else if (expired) err <= ERR_TIMEOUT;
      end
   end

   always_comb begin
      load_busy  = (state != ST_IDLE);
      core_start = (state == ST_DONE);
      core_hold  = hold;
      err_code   = err;
   end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed self-checking bench for inst_loader
module tb_inst_loader;
   logic        clk = 1'b0;
   logic        rst;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [12:0] wr_data;
   logic        core_hold, core_start, load_busy;
   logic [1:0]  err_code;
   int checks = 0;
   int failures = 0;
   int wcnt = 0;
   int base;

   always #5 clk = ~clk;

   inst_loader #(.TIMEOUT_CYCLES(100)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .core_hold (core_hold),
      .core_start(core_start),
      .load_busy (load_busy),
      .err_code  (err_code)
   );

   always @(negedge clk) if (wr_en) wcnt++;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Byte is strobed for one cycle; returns at the negedge after the accepting edge.
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_csum(input logic [7:0] b);
`ifdef LOADER_CHECKSUM_EN
      send(b);
`endif
   endtask

   // A5 02 {01 23} {00 45}; checksum 02^01^23^00^45 = 65
   task automatic frame_a(input string tag);
      send(8'hA5);
      send(8'h02);
      send(8'h01);
      send(8'h23);
      chk({tag, "_w0_en"}, 16'(wr_en), 16'h1);
      chk({tag, "_w0_addr"}, 16'(wr_addr), 16'h0);
      chk({tag, "_w0_data"}, 16'(wr_data), 16'h123);
      send(8'h00);
      send(8'h45);
      chk({tag, "_w1_en"}, 16'(wr_en), 16'h1);
      chk({tag, "_w1_addr"}, 16'(wr_addr), 16'h1);
      chk({tag, "_w1_data"}, 16'(wr_data), 16'h045);
      send_csum(8'h65);
      chk({tag, "_start"}, 16'(core_start), 16'h1);
      chk({tag, "_hold_t1"}, 16'(core_hold), 16'h1);
      @(negedge clk);
      chk({tag, "_hold_t2"}, 16'(core_hold), 16'h0);
      chk({tag, "_start_t2"}, 16'(core_start), 16'h0);
      chk({tag, "_busy_t2"}, 16'(load_busy), 16'h0);
      chk({tag, "_err"}, 16'(err_code), 16'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      rx_valid = 1'b0;
      rx_data = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_wr_en", 16'(wr_en), 16'h0);
      chk("rst_wr_addr", 16'(wr_addr), 16'h0);
      chk("rst_wr_data", 16'(wr_data), 16'h0);
      chk("rst_hold", 16'(core_hold), 16'h0);
      chk("rst_start", 16'(core_start), 16'h0);
      chk("rst_busy", 16'(load_busy), 16'h0);
      chk("rst_err", 16'(err_code), 16'h0);

      send(8'h11);
      send(8'h22);
      chk("stray_busy", 16'(load_busy), 16'h0);
      chk("stray_hold", 16'(core_hold), 16'h0);
      send(8'hA5);
      chk("sync_hold", 16'(core_hold), 16'h1);
      chk("sync_busy", 16'(load_busy), 16'h1);
      send(8'h02);
      send(8'h00);
      send(8'h11);
      chk("data_w0", 16'(wr_data), 16'h011);
      send(8'h00);
      send(8'hA5);
      chk("data_w1_en", 16'(wr_en), 16'h1);
      chk("data_w1_addr", 16'(wr_addr), 16'h1);
      chk("data_w1", 16'(wr_data), 16'h0A5);
      send_csum(8'hB6);
      chk("data_start", 16'(core_start), 16'h1);
      @(negedge clk);
      chk("data_err", 16'(err_code), 16'h0);
      chk("data_hold", 16'(core_hold), 16'h0);

      frame_a("fa");

`ifdef LOADER_CHECKSUM_EN
      base = wcnt;
      send(8'hA5);
      send(8'h02);
      send(8'h01);
      send(8'h23);
      send(8'h00);
      send(8'h45);
      send(8'h00);
      chk("cs_err", 16'(err_code), 16'h2);
      chk("cs_busy", 16'(load_busy), 16'h0);
      chk("cs_hold", 16'(core_hold), 16'h1);
      chk("cs_start", 16'(core_start), 16'h0);
      chk("cs_writes", 16'(wcnt - base), 16'h2);
      frame_a("cs_rel");
`endif

      base = wcnt;
      send(8'hA5);
      send(8'h01);
      send(8'h21);
      chk("hi_err", 16'(err_code), 16'h1);
      chk("hi_busy", 16'(load_busy), 16'h0);
      chk("hi_hold", 16'(core_hold), 16'h1);
      send(8'h45);
      chk("hi_writes", 16'(wcnt - base), 16'h0);
      frame_a("hi_rel");

      send(8'hA5);
      send(8'h02);
      repeat (90) @(negedge clk);
      chk("to_err_early", 16'(err_code), 16'h0);
      chk("to_busy_early", 16'(load_busy), 16'h1);
      repeat (20) @(negedge clk);
      chk("to_err", 16'(err_code), 16'h3);
      chk("to_busy", 16'(load_busy), 16'h0);
      chk("to_hold", 16'(core_hold), 16'h1);
      frame_a("to_rel");

      base = wcnt;
      send(8'hA5);
      send(8'h02);
      send(8'h01);
      send(8'h23);
      send(8'h00);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mr_wr_en", 16'(wr_en), 16'h0);
      chk("mr_wr_addr", 16'(wr_addr), 16'h0);
      chk("mr_wr_data", 16'(wr_data), 16'h0);
      chk("mr_hold", 16'(core_hold), 16'h0);
      chk("mr_busy", 16'(load_busy), 16'h0);
      chk("mr_err", 16'(err_code), 16'h0);
      send(8'h45);
      repeat (3) @(negedge clk);
      chk("mr_writes", 16'(wcnt - base), 16'h1);
      chk("mr_idle_busy", 16'(load_busy), 16'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
